counter_down_modulus_8bit: RTL



---
 rtl/counter_down_modulus_8bit.sv | 94 +++++++++
 1 files changed

// File: rtl/counter_down_modulus_8bit.sv
// Modulus-N down counter with programmable modulus, parallel load and enable.
// Auto-reload mode divides the enabled clock rate by the modulus; one-shot mode
// counts to zero, raises a sticky done flag and halts until reloaded.
// tc_out pulses for one enabled cycle per period so instances can be chained,
// with each stage's tc_out driving the next stage's en_in.
module counter_down_modulus_8bit #(
  parameter int WIDTH       = 8,
  parameter int MOD_DEFAULT = 46
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             en_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             mod_wr_in,
  input  logic [WIDTH-1:0] mod_in,
  input  logic             oneshot_in,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] mod_out,
  output logic             tc_out,
  output logic             done_out
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOD_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] MOD_RST = WIDTH'(MOD_DEFAULT);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(MOD_DEFAULT - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             done_q, done_d;

  // Highest legal count for the current modulus; also the reload value.
  logic [WIDTH-1:0] top_w;
  logic             at_zero_w;

  assign top_w     = mod_q - ONE;
  assign at_zero_w = (count_q == '0);

  // Count and done next-state: load beats decrement, decrement beats hold.
  // Load and reload both use the modulus as it stands before this edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    count_d = count_q;
    done_d  = done_q;
    if (load_in) begin
      count_d = (d_in < mod_q) ? d_in : top_w;
      done_d  = 1'b0;
    end else if (en_in && !done_q) begin
      if (count_q > top_w) begin
        // Modulus was lowered below the current count: snap into range.
        count_d = top_w;
      end else if (!at_zero_w) begin
        count_d = count_q - ONE;
      end else if (oneshot_in) begin
        // Hold at zero and latch completion until a load or reset.
        done_d = 1'b1;
      end else begin
        // Reload on the same edge, so the period is exactly mod_q cycles.
        count_d = top_w;
      end
    end
  end

  // Modulus next-state: writes of 0 or 1 would give a degenerate period and are dropped.
  always_comb begin
    mod_d = mod_q;
    if (mod_wr_in && (mod_in >= MOD_MIN)) begin
      mod_d = mod_in;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_ah_in) begin
      count_q <= CNT_RST;
      mod_q   <= MOD_RST;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign mod_out   = mod_q;
  assign done_out  = done_q;
  assign tc_out    = en_in & at_zero_w & ~done_q;

endmodule
